// File: rtl/wb_strobe_regbank.sv
`default_nettype none
// ============================================================================
// wb_strobe_regbank : Wishbone register bank with per-register rd/wr strobes
// Rev 1.0
// ============================================================================
module wb_strobe_regbank #(
  parameter int unsigned NREGS     = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  output logic [NREGS*32-1:0]   regs_o,
  output logic [NREGS-1:0]      wr_o,
  output logic [NREGS-1:0]      rd_o
);

  logic [31:0]       r_regs [NREGS];
  logic              r_rd_busy;
  logic              r_wr_busy;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_adr;
  logic [3:0]        r_wr_sel;
  logic [31:0]       r_wr_dat;
  logic              r_rd_ack;
  logic              r_rd_err;
  logic [31:0]       r_rd_dat;
  logic [NREGS-1:0]  r_rd_stb;
  logic [NREGS-1:0]  r_wr_stb;

  logic              w_en;
  logic              w_accept;
  logic              w_rd_req;
  logic              w_wr_req;
  logic              w_rd_hit;
  logic              w_wr_hit;
  logic [31:0]       w_rd_data;
  logic [NREGS-1:0]  w_rd_onehot;
  logic [NREGS-1:0]  w_wr_onehot;

  // A request held by the master across its ack cycle must not be taken twice.
  assign w_en     = wb_cyc_i & wb_stb_i;
  assign w_accept = w_en & ~r_rd_busy & ~r_wr_busy;
  assign w_rd_req = w_accept & ~wb_we_i;
  assign w_wr_req = w_accept & wb_we_i;
  assign w_rd_hit = 32'(wb_adr_i) < NREGS;
  assign w_wr_hit = 32'(r_wr_adr) < NREGS;

  always_comb begin
    w_rd_data   = '0;
    w_rd_onehot = '0;
    w_wr_onehot = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (32'(wb_adr_i) == i) begin
        w_rd_data      = r_regs[i];
        w_rd_onehot[i] = 1'b1;
      end
      if (32'(r_wr_adr) == i) begin
        w_wr_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (r_wr_valid) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (w_wr_onehot[i] && r_wr_sel[k]) begin
            r_regs[i][8*k +: 8] <= r_wr_dat[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_busy  <= 1'b0;
      r_wr_busy  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_adr   <= '0;
      r_wr_sel   <= '0;
      r_wr_dat   <= '0;
      r_rd_ack   <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_dat   <= '0;
      r_rd_stb   <= '0;
      r_wr_stb   <= '0;
    end else begin
      if (w_rd_req) begin
        r_rd_busy <= 1'b1;
      end else if (r_rd_ack || r_rd_err) begin
        r_rd_busy <= 1'b0;
      end
      if (w_wr_req) begin
        r_wr_busy <= 1'b1;
      end else if (r_wr_valid) begin
        r_wr_busy <= 1'b0;
      end

      r_wr_valid <= w_wr_req;
      if (w_wr_req) begin
        r_wr_adr <= wb_adr_i;
        r_wr_sel <= wb_sel_i;
        r_wr_dat <= wb_dat_i;
      end
      r_wr_stb <= r_wr_valid ? w_wr_onehot : '0;

      r_rd_ack <= w_rd_req & w_rd_hit;
      r_rd_err <= w_rd_req & ~w_rd_hit;
      r_rd_dat <= w_rd_req ? w_rd_data : '0;
      r_rd_stb <= w_rd_req ? w_rd_onehot : '0;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_pack
    assign regs_o[32*i +: 32] = r_regs[i];
  end

  assign wb_ack_o   = r_rd_ack | (r_wr_valid & w_wr_hit);
  assign wb_err_o   = r_rd_err | (r_wr_valid & ~w_wr_hit);
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = w_en & ~(wb_ack_o | wb_err_o);
  assign wb_dat_o   = r_rd_dat;
  assign wr_o       = r_wr_stb;
  assign rd_o       = r_rd_stb;

endmodule
`default_nettype wire

// File: tb/tb_wb_strobe_regbank.sv
`default_nettype none
// ============================================================================
// tb_wb_strobe_regbank : directed self-checking bench for wb_strobe_regbank
// Rev 1.0
// ============================================================================
module tb_wb_strobe_regbank;

  localparam int NREGS  = 4;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cyc = 1'b0;
  logic                stb = 1'b0;
  logic [ADDR_W-1:0]   adr = '0;
  logic [3:0]          sel = '0;
  logic                we = 1'b0;
  logic [31:0]         dat_w = '0;
  logic                ack;
  logic                err;
  logic                rty;
  logic                stall;
  logic [31:0]         dat_r;
  logic [NREGS*32-1:0] regs;
  logic [NREGS-1:0]    wr;
  logic [NREGS-1:0]    rd;

  int n_vec  = 0;
  int n_miss = 0;
  logic [127:0] exp_regs = '0;

  wb_strobe_regbank #(
    .NREGS     (NREGS),
    .ADDR_W    (ADDR_W),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_adr_i   (adr),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_dat_i   (dat_w),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_rty_o   (rty),
    .wb_stall_o (stall),
    .wb_dat_o   (dat_r),
    .regs_o     (regs),
    .wr_o       (wr),
    .rd_o       (rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                          input bit ok);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat_w = d;
    #1 chk("wr_stall_n", stall, 1);
    step();
    chk("wr_ack_n1", ack, ok);
    chk("wr_err_n1", err, !ok);
    chk("wr_stall_n1", stall, 0);
    idle();
    step();
    chk("wr_term_once", {ack, err}, 0);
    chk("wr_strobe_n2", wr, ok ? (4'b0001 << a) : 4'b0000);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp_d, input bit ok);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    #1 chk("rd_stall_n", stall, 1);
    step();
    chk("rd_ack_n1", ack, ok);
    chk("rd_err_n1", err, !ok);
    chk("rd_data_n1", dat_r, exp_d);
    chk("rd_strobe_n1", rd, ok ? (4'b0001 << a) : 4'b0000);
    idle();
    step();
    chk("rd_term_once", {ack, err}, 0);
    chk("rd_data_idle", dat_r, 0);
    chk("rd_strobe_idle", rd, 0);
  endtask

  initial begin
    #1;
    chk("rst_regs", regs, 0);
    chk("rst_ack_err", {ack, err, rty}, 0);
    chk("rst_dat", dat_r, 0);
    chk("rst_strobes", {wr, rd}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_read(3'd2, 32'h0000_0000, 1'b1);

    do_write(3'd1, 4'hF, 32'hA5A5_A5A5, 1'b1);
    exp_regs[63:32] = 32'hA5A5_A5A5;
    chk("regs_adr1", regs, exp_regs);
    do_read(3'd1, 32'hA5A5_A5A5, 1'b1);

    do_write(3'd3, 4'hF, 32'hFFFF_FFFF, 1'b1);
    do_write(3'd3, 4'b0101, 32'h1122_3344, 1'b1);
    exp_regs[127:96] = 32'hFF22_FF44;
    chk("regs_adr3_sel", regs, exp_regs);
    do_read(3'd3, 32'hFF22_FF44, 1'b1);

    do_write(3'd5, 4'hF, 32'h5555_5555, 1'b0);
    chk("regs_oor_wr", regs, exp_regs);
    do_read(3'd5, 32'h0000_0000, 1'b0);

    do_write(3'd0, 4'hF, 32'h1234_5678, 1'b1);
    exp_regs[31:0] = 32'h1234_5678;
    do_write(3'd0, 4'b0000, 32'hDEAD_BEEF, 1'b1);
    chk("regs_sel0", regs, exp_regs);
    do_read(3'd0, 32'h1234_5678, 1'b1);

    // Reset lands in the decode cycle of a write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd2; sel = 4'hF; dat_w = 32'hCAFE_F00D;
    step();
    rst_n = 1'b0;
    idle();
    #1;
    exp_regs = '0;
    chk("midrst_ack", {ack, err}, 0);
    chk("midrst_regs", regs, exp_regs);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_ack", {ack, err}, 0);
      chk("postrst_wr", wr, 0);
      chk("postrst_regs", regs, exp_regs);
    end
    do_read(3'd2, 32'h0000_0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
